issueq_valid_tracker: RTL and testbench

Tracks which issue-queue entries hold live instructions, for the issue stage. It is the inverse companion of the one-hot-to-binary encoder used by the select logic. Each cycle it accepts binary entry indices from dispatch (allocate) and from select/grant (issue). It decodes them into one-hot set and clear masks and maintains a registered valid vector, free vector, occupancy count and protocol-error flag for the free-list and wakeup logic.

---
 rtl/issueq_valid_tracker.sv | 97 +++++++++
 tb/tb_issueq_valid_tracker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issueq_valid_tracker.sv
`timescale 1ns / 1ps
// Issue-queue valid tracker: decodes binary allocate/grant indices into one-hot set/clear
// masks and keeps the registered valid vector, occupancy count and sticky protocol error.
module issueq_valid_tracker #(
  parameter int unsigned IQ_DEPTH       = 32,
  parameter int unsigned IQ_INDEX       = 5,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned ISSUE_WIDTH    = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flush_i,
  input  logic [DISPATCH_WIDTH-1:0]                dispValid_i,
  input  logic [DISPATCH_WIDTH-1:0][IQ_INDEX-1:0]  dispIndex_i,
  input  logic [ISSUE_WIDTH-1:0]                   grantValid_i,
  input  logic [ISSUE_WIDTH-1:0][IQ_INDEX-1:0]     grantIndex_i,
  output logic [IQ_DEPTH-1:0]                      validVector_o,
  output logic [IQ_DEPTH-1:0]                      freeVector_o,
  output logic [IQ_INDEX:0]                        count_o,
  output logic                                     empty_o,
  output logic                                     full_o,
  output logic                                     error_o
);

  logic [IQ_DEPTH-1:0] valid_q, valid_d;
  logic [IQ_INDEX:0]   count_q, count_d;
  logic                error_q, error_d;

  logic [IQ_DEPTH-1:0] set_mask, clr_mask;
  logic                proto_err;

  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    proto_err = 1'b0;

    // Building the masks lane by lane exposes duplicate indices as already-set mask bits.
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (dispValid_i[i]) begin
        if (32'(dispIndex_i[i]) >= IQ_DEPTH) begin
          proto_err = 1'b1;
        end else begin
          if (set_mask[dispIndex_i[i]] || valid_q[dispIndex_i[i]]) proto_err = 1'b1;
          set_mask[dispIndex_i[i]] = 1'b1;
        end
      end
    end

    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      if (grantValid_i[i]) begin
        if (32'(grantIndex_i[i]) >= IQ_DEPTH) begin
          proto_err = 1'b1;
        end else begin
          if (clr_mask[grantIndex_i[i]] || !valid_q[grantIndex_i[i]]) proto_err = 1'b1;
          clr_mask[grantIndex_i[i]] = 1'b1;
        end
      end
    end

    if (|(set_mask & clr_mask)) proto_err = 1'b1;
  end

  always_comb begin
    valid_d = (valid_q & ~clr_mask) | set_mask;
    error_d = error_q | proto_err;
    if (flush_i) begin
      valid_d = '0;
      error_d = error_q;
    end

    // Full recount rather than an incremental update, so the count can never drift.
    count_d = '0;
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      count_d = count_d + {{IQ_INDEX{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign validVector_o = valid_q;
  assign freeVector_o  = ~valid_q;
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == (IQ_INDEX + 1)'(IQ_DEPTH));
  assign error_o       = error_q;

endmodule

// File: tb/tb_issueq_valid_tracker.sv
`timescale 1ns / 1ps
// Randomised and directed bench for issueq_valid_tracker against a set-based reference model;
// a second 24-entry instance covers out-of-range indices.
module tb_issueq_valid_tracker;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [3:0]       dv, gv;
  logic [3:0][4:0]  di, gi;
  logic [31:0]      vv, fv;
  logic [5:0]       cnt;
  logic             emp, ful, err;

  logic             flush24;
  logic [3:0]       dv24, gv24;
  logic [3:0][4:0]  di24, gi24;
  logic [23:0]      vv24, fv24;
  logic [5:0]       cnt24;
  logic             emp24, ful24, err24;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the set of valid entry numbers plus the sticky error bit.
  bit mv[int];
  bit merr;

  always #5 clk = ~clk;

  issueq_valid_tracker #(
    .IQ_DEPTH(32), .IQ_INDEX(5), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4)
  ) u_dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .dispValid_i(dv), .dispIndex_i(di), .grantValid_i(gv), .grantIndex_i(gi),
    .validVector_o(vv), .freeVector_o(fv), .count_o(cnt),
    .empty_o(emp), .full_o(ful), .error_o(err)
  );

  issueq_valid_tracker #(
    .IQ_DEPTH(24), .IQ_INDEX(5), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4)
  ) u_dut24 (
    .clk(clk), .reset(reset), .flush_i(flush24),
    .dispValid_i(dv24), .dispIndex_i(di24), .grantValid_i(gv24), .grantIndex_i(gi24),
    .validVector_o(vv24), .freeVector_o(fv24), .count_o(cnt24),
    .empty_o(emp24), .full_o(ful24), .error_o(err24)
  );

  function automatic void model_step(input logic fl, input logic [3:0] dvv,
                                     input logic [3:0][4:0] div, input logic [3:0] gvv,
                                     input logic [3:0][4:0] giv);
    bit setm[int];
    bit clrm[int];
    bit e = 0;
    if (fl) begin
      mv.delete();
      return;
    end
    for (int l = 0; l < 4; l++) begin
      if (dvv[l]) begin
        int k = int'(div[l]);
        if (setm.exists(k) || mv.exists(k)) e = 1;
        setm[k] = 1;
      end
      if (gvv[l]) begin
        int k = int'(giv[l]);
        if (clrm.exists(k) || !mv.exists(k)) e = 1;
        clrm[k] = 1;
      end
    end
    foreach (setm[k]) if (clrm.exists(k)) e = 1;
    foreach (clrm[k]) mv.delete(k);
    foreach (setm[k]) mv[k] = 1;
    merr = merr | e;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    foreach (mv[k]) v[k] = 1'b1;
    return v;
  endfunction

  // Apply one cycle of stimulus; returns 1 ns after the edge so outputs are stable.
  task automatic drive(input logic rst, input logic fl, input logic [3:0] dvv,
                       input logic [3:0][4:0] div, input logic [3:0] gvv,
                       input logic [3:0][4:0] giv);
    reset = rst; flush = fl; dv = dvv; di = div; gv = gvv; gi = giv;
    if (!rst) begin
      mv.delete();
      merr = 0;
    end else begin
      model_step(fl, dvv, div, gvv, giv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'h0, '0, 4'h0, '0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, '0, 4'h0, '0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'($urandom), 4'($urandom), 20'($urandom), 4'($urandom), 20'($urandom));
    end
    n_checks++;
    if (vv !== 32'h0 || fv !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset_vectors: got valid=%h free=%h want 00000000/ffffffff", vv, fv);
    end
    n_checks++;
    if (cnt !== 6'd0 || emp !== 1'b1 || ful !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got cnt=%0d empty=%b full=%b err=%b want 0/1/0/0",
               cnt, emp, ful, err);
    end
  endtask

  task automatic test_multi_alloc();
    do_reset();
    drive(1'b1, 1'b0, 4'hF, {5'd0, 5'd5, 5'd31, 5'd17}, 4'h0, '0);
    n_checks++;
    if (vv !== 32'h8002_0021 || cnt !== 6'd4) begin
      n_fail++;
      $display("FAIL multi_alloc: got valid=%h cnt=%0d want 80020021/4", vv, cnt);
    end
    drive(1'b1, 1'b0, 4'h0, '0, 4'h3, {5'd0, 5'd0, 5'd5, 5'd17});
    n_checks++;
    if (vv !== 32'h8000_0001 || cnt !== 6'd2 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_grant: got valid=%h cnt=%0d err=%b want 80000001/2/0", vv, cnt, err);
    end
  endtask

  task automatic test_fill_reuse();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      logic [3:0][4:0] idx;
      for (int l = 0; l < 4; l++) idx[l] = 5'(4 * c + l);
      drive(1'b1, 1'b0, 4'hF, idx, 4'h0, '0);
    end
    n_checks++;
    if (ful !== 1'b1 || cnt !== 6'd32 || emp !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b cnt=%0d empty=%b want 1/32/0", ful, cnt, emp);
    end
    drive(1'b1, 1'b0, 4'h0, '0, 4'h1, {15'd0, 5'd9});
    n_checks++;
    if (cnt !== 6'd31 || fv !== 32'h0000_0200 || ful !== 1'b0) begin
      n_fail++;
      $display("FAIL grant9: got cnt=%0d free=%h full=%b want 31/00000200/0", cnt, fv, ful);
    end
    drive(1'b1, 1'b0, 4'h4, {5'd0, 5'd9, 10'd0}, 4'h0, '0);
    n_checks++;
    if (ful !== 1'b1 || cnt !== 6'd32 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL realloc9: got full=%b cnt=%0d err=%b want 1/32/0", ful, cnt, err);
    end
  endtask

  // Error must appear one cycle after the offending edge and survive idle cycles and a flush.
  task automatic check_sticky(input string name);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_raise: got err=%b want 1", name, err);
    end
    idle();
    idle();
    drive(1'b1, 1'b1, 4'h0, '0, 4'h0, '0);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_sticky: got err=%b want 1", name, err);
    end
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_clear: got err=%b want 0 after reset", name, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(1'b1, 1'b0, 4'h1, {15'd0, 5'd3}, 4'h0, '0);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc3_legal: got err=%b want 0", err);
    end
    drive(1'b1, 1'b0, 4'h2, {10'd0, 5'd3, 5'd0}, 4'h0, '0);
    check_sticky("alloc_valid");

    drive(1'b1, 1'b0, 4'h0, '0, 4'h1, {15'd0, 5'd12});
    check_sticky("grant_invalid");

    drive(1'b1, 1'b0, 4'h9, {5'd7, 10'd0, 5'd7}, 4'h0, '0);
    n_checks++;
    if (cnt !== 6'd1 || vv !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL dup_alloc_count: got cnt=%0d valid=%h want 1/00000080", cnt, vv);
    end
    check_sticky("dup_alloc");

    dv24 = 4'h1; di24 = {15'd0, 5'd30};
    idle();
    dv24 = 4'h0; di24 = '0;
    n_checks++;
    if (err24 !== 1'b1 || vv24 !== 24'h0 || cnt24 !== 6'd0) begin
      n_fail++;
      $display("FAIL out_of_range: got err=%b valid=%h cnt=%0d want 1/000000/0",
               err24, vv24, cnt24);
    end
    idle();
    n_checks++;
    if (err24 !== 1'b1) begin
      n_fail++;
      $display("FAIL out_of_range_sticky: got err=%b want 1", err24);
    end
    do_reset();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 1'b0, 4'hF, {5'd0, 5'd1, 5'd2, 5'd3}, 4'h0, '0);
    drive(1'b1, 1'b0, 4'hF, {5'd4, 5'd5, 5'd6, 5'd7}, 4'h0, '0);
    drive(1'b1, 1'b0, 4'h3, {10'd0, 5'd8, 5'd9}, 4'h0, '0);
    n_checks++;
    if (cnt !== 6'd10) begin
      n_fail++;
      $display("FAIL flush_setup: got cnt=%0d want 10", cnt);
    end
    drive(1'b1, 1'b1, 4'h3, {10'd0, 5'd1, 5'd2}, 4'h1, {15'd0, 5'd4});
    n_checks++;
    if (vv !== 32'h0 || cnt !== 6'd0 || emp !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_priority: got valid=%h cnt=%0d empty=%b err=%b want 0/0/1/0",
               vv, cnt, emp, err);
    end
  endtask

  task automatic test_set_clear();
    do_reset();
    drive(1'b1, 1'b0, 4'h1, {15'd0, 5'd6}, 4'h0, '0);
    drive(1'b1, 1'b0, 4'h1, {15'd0, 5'd6}, 4'h1, {15'd0, 5'd6});
    n_checks++;
    if (vv !== 32'h0000_0040 || cnt !== 6'd1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL set_clear: got valid=%h cnt=%0d err=%b want 00000040/1/1", vv, cnt, err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic            rst = ($urandom_range(0, 79) != 0);
      logic            fl  = ($urandom_range(0, 24) == 0);
      logic [3:0]      rdv = 4'($urandom);
      logic [3:0]      rgv = 4'($urandom);
      logic [3:0][4:0] rdi, rgi;
      logic [31:0]     ev;
      for (int l = 0; l < 4; l++) begin
        rdi[l] = 5'($urandom_range(0, 31));
        rgi[l] = 5'($urandom_range(0, 31));
      end
      drive(rst, fl, rdv, rdi, rgv, rgi);
      ev = model_vec();
      n_checks++;
      if (vv !== ev || fv !== ~ev) begin
        n_fail++;
        $display("FAIL rand_vec[%0d]: got valid=%h free=%h want %h/%h", c, vv, fv, ev, ~ev);
      end
      n_checks++;
      if (cnt !== 6'(mv.num()) || emp !== (mv.num() == 0) || ful !== (mv.num() == 32)) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got cnt=%0d empty=%b full=%b want cnt=%0d",
                 c, cnt, emp, ful, mv.num());
      end
      n_checks++;
      if (err !== merr) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: got err=%b want %b", c, err, merr);
      end
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; dv = '0; di = '0; gv = '0; gi = '0;
    flush24 = 1'b0; dv24 = '0; di24 = '0; gv24 = '0; gi24 = '0;
    merr = 0;
    #2;
    test_reset();
    test_multi_alloc();
    test_fill_reuse();
    test_errors();
    test_flush();
    test_set_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
